// File: rtl/demod_slicer_pipe.sv
// Sample slicer: maps an unsigned sample to a segment index, an in-segment offset
// and a saturation flag. Results go through a fixed-latency pipeline into an
// output FIFO, and occupancy credit on the input side keeps the FIFO from overflowing.
module demod_slicer_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEG_COUNT  = 10,
    parameter int unsigned STEP       = 100,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned SYM_W     = ($clog2(SEG_COUNT) > 1) ? $clog2(SEG_COUNT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic [DATA_W-1:0] out_resid,
    output logic              out_sat,
    output logic              busy
);

    localparam int unsigned PTR_W = ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // The compare is wide enough to hold SEG_COUNT*STEP without truncation.
    localparam int unsigned CMP_W = ((DATA_W > 64) ? DATA_W : 64) + 1;
    localparam logic [CMP_W-1:0] TOP_LIM = CMP_W'(SEG_COUNT) * CMP_W'(STEP);
    localparam logic [CMP_W-1:0] SYM_MAX = CMP_W'(SEG_COUNT - 1);
    localparam logic [CMP_W-1:0] STEP_W  = CMP_W'(STEP);

    typedef struct packed {
        logic              sat;
        logic [SYM_W-1:0]  sym;
        logic [DATA_W-1:0] resid;
    } word_t;

    word_t              slice;
    logic [CMP_W-1:0]   in_w;
    logic [CMP_W-1:0]   quot;

    logic [LATENCY-1:0] stg_valid;
    word_t              stg_data [LATENCY];
    word_t              mem [FIFO_DEPTH];

    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n;
    logic [CNT_W-1:0]   fifo_cnt, fifo_cnt_n, cnt_after_pop;
    logic [CNT_W-1:0]   occ, occ_n;
    logic               accept, pop, wr;
    word_t              head_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign in_ready = (occ < CNT_W'(FIFO_DEPTH)) && !reset;
    assign busy     = (occ != '0);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign wr       = stg_valid[LATENCY-1];

    // Slice the incoming sample into segment index, offset and saturation flag.
    always_comb begin
        in_w = CMP_W'(in_sample);
        quot = in_w / STEP_W;
        if (quot > SYM_MAX) quot = SYM_MAX;
        slice.sym   = SYM_W'(quot);
        slice.resid = DATA_W'(in_w - quot * STEP_W);
        slice.sat   = (in_w >= TOP_LIM);
    end

    // Stage valid bits: these shift every cycle and never stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
        end else begin
            stg_valid[0] <= accept;
            for (int i = 1; i < int'(LATENCY); i++) stg_valid[i] <= stg_valid[i-1];
        end
    end

    // Stage payloads are qualified by the valid bits, so they have no reset.
    always_ff @(posedge clk) begin
        stg_data[0] <= slice;
        for (int i = 1; i < int'(LATENCY); i++) stg_data[i] <= stg_data[i-1];
    end

    // A word enters the FIFO storage at the edge that ends its last stage.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= stg_data[LATENCY-1];
    end

    // Compute the next FIFO state, the next head word and the next occupancy.
    always_comb begin
        rd_ptr_n      = pop ? ptr_inc(rd_ptr) : rd_ptr;
        cnt_after_pop = fifo_cnt - CNT_W'(pop);
        fifo_cnt_n    = cnt_after_pop + CNT_W'(wr);
        occ_n         = occ + CNT_W'(accept) - CNT_W'(pop);
        head_n        = '0;
        if (cnt_after_pop != '0) head_n = mem[rd_ptr_n];
        else if (wr)             head_n = stg_data[LATENCY-1];
    end

    // Control registers and the registered output head.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_resid <= '0;
            out_sat   <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr ? ptr_inc(wr_ptr) : wr_ptr;
            fifo_cnt  <= fifo_cnt_n;
            occ       <= occ_n;
            out_valid <= (fifo_cnt_n != '0);
            out_sym   <= head_n.sym;
            out_resid <= head_n.resid;
            out_sat   <= head_n.sat;
        end
    end

endmodule

// File: tb/tb_demod_slicer_pipe.sv
// Directed bench for demod_slicer_pipe using the default parameters.
module tb_demod_slicer_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sample;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sym;
    logic [31:0] out_resid;
    logic        out_sat;
    logic        busy;

    always #5 clk = ~clk;

    demod_slicer_pipe #(
        .DATA_W(32), .SEG_COUNT(10), .STEP(100), .LATENCY(3), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
        .out_sym(out_sym), .out_resid(out_resid), .out_sat(out_sat), .busy(busy)
    );

    typedef struct packed {
        logic        sat;
        logic [3:0]  sym;
        logic [31:0] resid;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   cur    = 0;
    bit   auto_push = 1'b1;

    function automatic exp_t model(input logic [31:0] x);
        exp_t        e;
        int unsigned s;
        s = x / 100;
        if (s > 9) s = 9;
        e.sym   = 4'(s);
        e.resid = x - s * 100;
        e.sat   = (x >= 32'd1000);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Account for the handshakes that happen at the coming edge, then advance one cycle.
    task automatic tick(output bit acc);
        exp_t e;
        acc = in_valid && in_ready;
        if (acc && auto_push) q.push_back(model(in_sample));
        if (out_valid && out_ready) begin
            check("pop_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_sym", 64'(out_sym), 64'(e.sym));
                check("out_resid", 64'(out_resid), 64'(e.resid));
                check("out_sat", 64'(out_sat), 64'(e.sat));
            end
            pops++;
        end
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic drain(input int max_cyc);
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            if (q.size() == 0 && !busy) break;
            tick(a);
        end
        check("drain_queue", 64'(q.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        bit         a;
        int         acc_cnt;
        int         first;
        int         pops0;
        logic [3:0] h_sym;
        logic [31:0] h_res;
        logic       h_sat;
        logic [31:0] bvals [6];
        logic [3:0]  bsym  [6];
        logic [31:0] bres  [6];
        logic        bsat  [6];

        bvals = '{32'd0, 32'd99, 32'd100, 32'd999, 32'd1000, 32'd1234};
        bsym  = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd9, 4'd9};
        bres  = '{32'd0, 32'd99, 32'd0, 32'd99, 32'd100, 32'd334};
        bsat  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sample = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sym", 64'(out_sym), 64'd0);
        check("rst_out_resid", 64'(out_resid), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single sample 250: out_valid only in cycle 4, busy in cycles 1..4
        in_sample = 32'd250; in_valid = 1'b1; out_ready = 1'b1;
        tick(a);
        check("single_acc", 64'(a), 64'd1);
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("single_busy", 64'(busy), 64'(c <= 4));
            check("single_valid", 64'(out_valid), 64'(c == 4));
            if (c == 4) begin
                check("single_sym", 64'(out_sym), 64'd2);
                check("single_resid", 64'(out_resid), 64'd50);
                check("single_sat", 64'(out_sat), 64'd0);
            end
            tick(a);
        end
        check("single_queue", 64'(q.size()), 64'd0);

        // Segment boundaries, with hand-computed expectations
        auto_push = 1'b0;
        for (int i = 0; i < 6; i++) q.push_back('{sat: bsat[i], sym: bsym[i], resid: bres[i]});
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sample = bvals[i];
            tick(a);
            check("bnd_acc", 64'(a), 64'd1);
        end
        drain(50);
        auto_push = 1'b1;

        // Backpressure: 12 offers while stalled, exactly 8 accepted
        out_ready = 1'b0; acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_sample = 32'(300 + 77 * acc_cnt);
            tick(a);
            if (a) acc_cnt++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt), 64'd8);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        h_sym = out_sym; h_res = out_resid; h_sat = out_sat;
        for (int i = 0; i < 4; i++) begin
            tick(a);
            check("bp_stable_valid", 64'(out_valid), 64'd1);
            check("bp_stable_sym", 64'(out_sym), 64'(h_sym));
            check("bp_stable_resid", 64'(out_resid), 64'(h_res));
            check("bp_stable_sat", 64'(out_sat), 64'(h_sat));
        end

        // Occupancy 8: pop only. Occupancy 7: accept and pop together leave 7.
        in_valid = 1'b1; in_sample = 32'd4321; out_ready = 1'b1;
        check("occ8_in_ready", 64'(in_ready), 64'd0);
        tick(a);
        check("occ8_no_acc", 64'(a), 64'd0);
        check("occ7_in_ready", 64'(in_ready), 64'd1);
        tick(a);
        check("occ7_acc_pop", 64'(a), 64'd1);
        out_ready = 1'b0; in_sample = 32'd555;
        check("occ7_hold_ready", 64'(in_ready), 64'd1);
        tick(a);
        check("occ7_fill_acc", 64'(a), 64'd1);
        check("occ8_again", 64'(in_ready), 64'd0);
        drain(100);

        // Full rate: 100 back-to-back samples with the first output in cycle 4
        out_ready = 1'b1; cur = 0; first = -1; pops0 = pops;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_sample = 32'((i * 37) % 1300);
            check("full_in_ready", 64'(in_ready), 64'd1);
            if (out_valid && first < 0) first = cur;
            tick(a);
        end
        drain(50);
        check("full_first_cycle", 64'(first), 64'd4);
        check("full_count", 64'(pops - pops0), 64'd100);

        // Reset mid-operation: 3 in flight and 2 buffered are discarded
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sample = 32'(111 * (i + 1));
            tick(a);
            check("mid_acc", 64'(a), 64'd1);
        end
        in_valid = 1'b0;
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        check("mid_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick(a);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_resid", 64'(out_resid), 64'd0);
        q.delete();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("mid_no_stale", 64'(out_valid), 64'd0);
            tick(a);
        end
        check("mid_busy_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
